gemm_vector_feeder: RTL and testbench

- Transmit-side front end for the fixed-weights systolic GEMM.
- Accepts activation vectors over a valid/ready stream and drives them into the GEMM activation inputs, driving zero bubbles when idle.
- Tracks every issued vector through the fixed 2*SA_SIZE GEMM latency and returns each result vector, tagged with its row index and last flag, on a backpressured result stream.
- A result-FIFO credit scheme guarantees that no GEMM output is ever dropped.

---
 rtl/gemm_vector_feeder_pkg.sv | 25 ++
 rtl/gemm_result_fifo.sv | 80 ++++++++
 rtl/gemm_vector_feeder.sv | 183 ++++++++++++++++++
 tb/tb_gemm_vector_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_vector_feeder_pkg.sv
// ============================================================================
// Module      : gemm_vector_feeder_pkg
// Description : Shared helpers for the GEMM vector feeder: fixed GEMM latency
//               as a function of array size, and counter width for a FIFO of
//               a given depth (must hold the value DEPTH itself).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gemm_vector_feeder_pkg;

    // Cycles from a vector driving the GEMM activation inputs until its
    // result appears on the GEMM activation outputs.
    function automatic int feeder_latency(input int sa_size);
        return 2 * sa_size;
    endfunction

    // Width needed to count 0..depth inclusive.
    function automatic int feeder_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gemm_result_fifo.sv
// ============================================================================
// Module      : gemm_result_fifo
// Description : Synchronous FIFO without fall-through. Pop side is a
//               valid/ready stream; head data is held stable until popped
//               and reads as zero while empty. Pushes at full are ignored
//               (the feeder's credit scheme keeps that from happening).
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active high)
//               push_i / push_data_i         write side
//               pop_valid_o / pop_ready_i / pop_data_o  read stream
//               count_o                      current occupancy 0..DEPTH
// ============================================================================
`default_nettype none

module gemm_result_fifo
    import gemm_vector_feeder_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = feeder_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              pop_valid_o,
    input  logic              pop_ready_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_full      = (count_q == CNT_W'(DEPTH));
    assign w_do_push   = push_i && !w_full;
    assign pop_valid_o = (count_q != '0);
    assign w_do_pop    = pop_valid_o && pop_ready_i;

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data_o = pop_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

`default_nettype wire

// File: rtl/gemm_vector_feeder.sv
// ============================================================================
// Module      : gemm_vector_feeder
// Description : Transmit-side front end for the fixed-weights systolic GEMM.
//               Registers accepted activation vectors onto the GEMM inputs
//               (zero bubbles when idle), tracks each through the fixed
//               2*SA_SIZE GEMM latency with a tag pipe, captures the result
//               into a FIFO and returns it tagged with row index and last.
//               A credit count (in flight + queued) bounds acceptance so the
//               FIFO can never overflow.
// Revision    : 1.0 - initial release
// Config      : `define GEMM_FEEDER_PROTOCOL_CHECK_EN builds a sticky err
//               flag (tag exit without gemm_output_valid, or push at full);
//               otherwise err is tied to 0.
// Ports       : clk, reset (async, active high)
//               in_valid / in_ready / in_vector / in_last   input stream
//               gemm_activation_inputs  -> GEMM
//               gemm_activation_outputs, gemm_output_valid <- GEMM
//               res_valid / res_ready / res_vector / res_index / res_last
//               busy, err
// ============================================================================
`default_nettype none

module gemm_vector_feeder
    import gemm_vector_feeder_pkg::*;
#(
    parameter int SA_SIZE                = 4,
    parameter int WEIGHT_ACTIVATION_SIZE = 8,
    parameter int RESULT_FIFO_DEPTH      = 8,
    parameter int ROW_IDX_W              = 8
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      in_vector,
    input  logic                                                in_last,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      gemm_activation_inputs,
    input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      gemm_activation_outputs,
    input  logic                                                gemm_output_valid,
    output logic                                                res_valid,
    input  logic                                                res_ready,
    output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      res_vector,
    output logic [ROW_IDX_W-1:0]                                res_index,
    output logic                                                res_last,
    output logic                                                busy,
    output logic                                                err
);

    localparam int LATENCY = feeder_latency(SA_SIZE);
    localparam int CNT_W   = feeder_cnt_w(RESULT_FIFO_DEPTH);
    localparam int VEC_W   = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
    localparam int ENTRY_W = VEC_W + ROW_IDX_W + 1;

    // Tag width depends on ROW_IDX_W, so the struct lives with the module.
    typedef struct packed {
        logic                 valid;
        logic [ROW_IDX_W-1:0] index;
        logic                 last;
    } feeder_tag_t;

    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] act_q;
    feeder_tag_t          issue_tag_q;
    feeder_tag_t          issue_tag_d;
    feeder_tag_t          tag_q [LATENCY];
    logic [ROW_IDX_W-1:0] idx_q;
    logic [ROW_IDX_W-1:0] idx_d;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_d;

    logic                 w_accept;
    feeder_tag_t          w_exit_tag;
    logic                 w_push;
    logic [CNT_W-1:0]     w_fifo_count;
    logic [CNT_W:0]       w_credits_used;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_pop_data;

    // Credits come from registered state only; a pop frees its credit one
    // cycle later, keeping res_ready off the in_ready path.
    assign w_credits_used = {1'b0, inflight_q} + {1'b0, w_fifo_count};
    assign in_ready       = (w_credits_used < (CNT_W + 1)'(RESULT_FIFO_DEPTH));
    assign busy           = (inflight_q != '0) || (w_fifo_count != '0);

    assign w_exit_tag = tag_q[LATENCY-1];
    assign w_push     = w_exit_tag.valid;

    always_comb begin
        w_accept = in_valid && in_ready;

        idx_d = idx_q;
        if (w_accept) begin
            idx_d = in_last ? '0 : idx_q + ROW_IDX_W'(1);
        end

        issue_tag_d.valid = w_accept;
        issue_tag_d.index = w_accept ? idx_q : '0;
        issue_tag_d.last  = w_accept && in_last;

        inflight_d = inflight_q;
        if (w_accept && !w_push) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!w_accept && w_push) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // issue_tag_q travels alongside act_q (the cycle the vector drives the
    // GEMM); the LATENCY-stage pipe behind it lines the tag up with the
    // GEMM output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q       <= '0;
            issue_tag_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            idx_q      <= '0;
            inflight_q <= '0;
        end else begin
            act_q       <= w_accept ? in_vector : '0;
            issue_tag_q <= issue_tag_d;
            tag_q[0]    <= issue_tag_q;
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
        end
    end

    assign gemm_activation_inputs = act_q;
    assign w_push_data = {gemm_activation_outputs, w_exit_tag.index, w_exit_tag.last};

    gemm_result_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (RESULT_FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_result_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_valid_o (res_valid),
        .pop_ready_i (res_ready),
        .pop_data_o  (w_pop_data),
        .count_o     (w_fifo_count)
    );

    assign {res_vector, res_index, res_last} = w_pop_data;

`ifdef GEMM_FEEDER_PROTOCOL_CHECK_EN
    logic err_q;
    logic w_fifo_full;

    assign w_fifo_full = (w_fifo_count == CNT_W'(RESULT_FIFO_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((w_push && !gemm_output_valid) || (w_push && w_fifo_full)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

  `ifdef FORMAL
    always @(posedge clk) begin
        if (!reset) begin
            assert (!w_push || gemm_output_valid);
            assert (!(w_push && w_fifo_full));
        end
    end
  `endif
`else
    logic w_unused_gemm_valid;
    assign w_unused_gemm_valid = gemm_output_valid;
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_vector_feeder.sv
// ============================================================================
// Module      : tb_gemm_vector_feeder
// Description : Directed self-checking bench for gemm_vector_feeder with
//               SA_SIZE=2 (latency 4), ROW_IDX_W=2 and a behavioural GEMM
//               holding weights [[3,0],[0,2]].
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gemm_vector_feeder;

    localparam int SA  = 2;
    localparam int W   = 8;
    localparam int DEP = 8;
    localparam int IW  = 2;
    localparam int LAT = 4;

    typedef logic [SA-1:0][W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    vec_t          in_vector = '0;
    logic          in_last = 1'b0;
    vec_t          gemm_in;
    vec_t          gemm_out;
    logic          gemm_valid;
    logic          res_valid;
    logic          res_ready = 1'b1;
    vec_t          res_vector;
    logic [IW-1:0] res_index;
    logic          res_last;
    logic          busy;
    logic          err;
    logic          force_bad = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gemm_vector_feeder #(
        .SA_SIZE                (SA),
        .WEIGHT_ACTIVATION_SIZE (W),
        .RESULT_FIFO_DEPTH      (DEP),
        .ROW_IDX_W              (IW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_vector               (in_vector),
        .in_last                 (in_last),
        .gemm_activation_inputs  (gemm_in),
        .gemm_activation_outputs (gemm_out),
        .gemm_output_valid       (gemm_valid),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_vector              (res_vector),
        .res_index               (res_index),
        .res_last                (res_last),
        .busy                    (busy),
        .err                     (err)
    );

    // Behavioural GEMM: diagonal weights 3 and 2, fixed latency LAT.
    logic acc_q;
    vec_t pipe_d [LAT];
    logic pipe_v [LAT];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_d[k] <= '0;
            end
        end else begin
            acc_q     <= in_valid && in_ready;
            pipe_v[0] <= acc_q;
            pipe_d[0] <= gemm_in;
            for (int k = 1; k < LAT; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    always_comb begin
        gemm_out[0] = pipe_d[LAT-1][0] * 8'd3;
        gemm_out[1] = pipe_d[LAT-1][1] * 8'd2;
        gemm_valid  = pipe_v[LAT-1] && !force_bad;
    end

    function automatic vec_t vec(input int a, input int b);
        vec_t v;
        v[0] = a[7:0];
        v[1] = b[7:0];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_vector = '0;
        res_ready = 1'b1;
        force_bad = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (gemm_in !== '0) begin miscompares++; $display("FAIL reset_gemm_in: got %h want 0", gemm_in); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        vectors++; if (res_index !== '0) begin miscompares++; $display("FAIL reset_res_index: got %0d want 0", res_index); end
        vectors++; if (res_last !== 1'b0) begin miscompares++; $display("FAIL reset_res_last: got %b want 0", res_last); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_vector = vec(2, 5); in_last = 1'b1; res_ready = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", in_ready); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0; in_vector = '0;
            if (k == 1) begin
                vectors++; if (gemm_in !== vec(2, 5)) begin miscompares++; $display("FAIL single_gemm_in: got %h want %h", gemm_in, vec(2, 5)); end
            end
            if (k == 2) begin
                vectors++; if (gemm_in !== '0) begin miscompares++; $display("FAIL single_bubble: got %h want 0", gemm_in); end
            end
            if (k < 6) begin
                vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid k=%0d: got %b want 0", k, res_valid); end
            end
            if (k == 6) begin
                vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", res_valid); end
                vectors++; if (res_vector !== vec(6, 10)) begin miscompares++; $display("FAIL single_data: got %h want %h", res_vector, vec(6, 10)); end
                vectors++; if ({res_index, res_last} !== {2'd0, 1'b1}) begin miscompares++; $display("FAIL single_tag: got idx %0d last %b want idx 0 last 1", res_index, res_last); end
            end
            if (k <= 6) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy k=%0d: got %b want 1", k, busy); end
            end else begin
                vectors++; if ({busy, res_valid} !== 2'b00) begin miscompares++; $display("FAIL single_done: got busy %b valid %b want 0 0", busy, res_valid); end
            end
        end
    endtask

    // Consecutive accepts (and the index-wrap case) share this shape:
    // n vectors on back-to-back cycles, results expected on back-to-back
    // cycles starting 6 cycles after the first accept.
    task automatic test_back_to_back(input string name, input int n,
                                     input int ia[5], input int ib[5],
                                     input int ra[5], input int rb[5],
                                     input int ridx[5], input int last_at);
        for (int k = 0; k <= n + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 6 && k < 6 + n) begin
                vectors++;
                if (res_valid !== 1'b1 || res_vector !== vec(ra[k-6], rb[k-6]) ||
                    res_index !== IW'(ridx[k-6]) || res_last !== (k - 6 == last_at)) begin
                    miscompares++;
                    $display("FAIL %s_result%0d: got v=%b %h idx %0d last %b want v=1 %h idx %0d last %b",
                             name, k - 6, res_valid, res_vector, res_index, res_last,
                             vec(ra[k-6], rb[k-6]), ridx[k-6], (k - 6 == last_at));
                end
            end else begin
                vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL %s_no_result k=%0d: got %b want 0", name, k, res_valid); end
            end
            if (k < n) begin
                in_valid = 1'b1; in_vector = vec(ia[k], ib[k]); in_last = (k == last_at);
            end else begin
                in_valid = 1'b0; in_vector = '0; in_last = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int bp_a [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        int bp_b [10] = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19};
        int ex_a [8]  = '{3, 6, 9, 12, 15, 18, 21, 24};
        int ex_b [8]  = '{2, 6, 10, 14, 18, 22, 26, 30};
        int accepted = 0;
        int n = 0;
        res_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_vector = vec(bp_a[accepted], bp_b[accepted]); in_last = 1'b0;
            if (in_ready) accepted++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_vector = '0;
        vectors++; if (accepted !== 8) begin miscompares++; $display("FAIL bp_accepted: got %0d want 8", accepted); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        vectors++; if ({res_valid, busy} !== 2'b11) begin miscompares++; $display("FAIL bp_held: got valid %b busy %b want 1 1", res_valid, busy); end
        vectors++; if (res_vector !== vec(3, 2)) begin miscompares++; $display("FAIL bp_head_stable: got %h want %h", res_vector, vec(3, 2)); end
        res_ready = 1'b1;
        for (int k = 0; k < 40 && n < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (res_valid) begin
                vectors++;
                if (res_vector !== vec(ex_a[n], ex_b[n]) || res_index !== IW'(n) || res_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_drain%0d: got %h idx %0d last %b want %h idx %0d last 0",
                             n, res_vector, res_index, res_last, vec(ex_a[n], ex_b[n]), n % 4);
                end
                n++;
            end
        end
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL bp_drain_count: got %0d want 8", n); end
        @(negedge clk);
        vectors++; if ({in_ready, busy, res_valid} !== 3'b100) begin miscompares++; $display("FAIL bp_empty: got ready %b busy %b valid %b want 1 0 0", in_ready, busy, res_valid); end
        // Acceptance resumes; 8 prior rows leave the index at 8 mod 4 = 0.
        in_valid = 1'b1; in_vector = vec(9, 17); in_last = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in_vector = '0; in_last = 1'b0;
        end
        vectors++;
        if (res_valid !== 1'b1 || res_vector !== vec(27, 34) || res_index !== 2'd0 || res_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume: got v=%b %h idx %0d last %b want v=1 %h idx 0 last 1",
                     res_valid, res_vector, res_index, res_last, vec(27, 34));
        end
    endtask

    task automatic test_idle();
        in_valid = 1'b0; in_vector = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if ({gemm_in, res_valid, busy} !== '0) begin
                miscompares++;
                $display("FAIL idle k=%0d: got gemm %h valid %b busy %b want 0 0 0", k, gemm_in, res_valid, busy);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid = 1'b1; in_vector = vec(j + 1, j + 1); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; in_vector = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if ({in_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL mid_reset_state: got ready %b busy %b want 1 0", in_ready, busy); end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ghost: got a result want none"); end
        in_valid = 1'b1; in_vector = vec(4, 4); in_last = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in_vector = '0; in_last = 1'b0;
        end
        vectors++;
        if (res_valid !== 1'b1 || res_vector !== vec(12, 8) || res_index !== 2'd0 || res_last !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_index: got v=%b %h idx %0d last %b want v=1 %h idx 0 last 1",
                     res_valid, res_vector, res_index, res_last, vec(12, 8));
        end
        @(negedge clk);
    endtask

    task automatic test_protocol_err();
`ifdef GEMM_FEEDER_PROTOCOL_CHECK_EN
        apply_reset();
        force_bad = 1'b1;
        in_valid = 1'b1; in_vector = vec(1, 1); in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_vector = '0; in_last = 1'b0;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_early: got %b want 0", err); end
        repeat (6) @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", err); end
        force_bad = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", err); end
        apply_reset();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", err); end
`else
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_tied: got %b want 0", err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back("stream", 3,
                          '{2, 3, 1, 0, 0}, '{5, 2, 1, 0, 0},
                          '{6, 9, 3, 0, 0}, '{10, 4, 2, 0, 0},
                          '{0, 1, 2, 0, 0}, 2);
        test_backpressure();
        test_idle();
        test_reset_midflight();
        // Index wrap with 2-bit indices; 100*3 and 200*2 also wrap mod 256.
        test_back_to_back("wrap", 5,
                          '{100, 1, 3, 5, 7}, '{200, 2, 4, 6, 8},
                          '{44, 3, 9, 15, 21}, '{144, 4, 8, 12, 16},
                          '{0, 1, 2, 3, 0}, -1);
        test_protocol_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
